fifo_sync_prog: RTL and testbench

Single-clock parametrised FIFO and the next-generation replacement for fifo_sync_top. It adds programmable almost-full/almost-empty thresholds, an occupancy count, a synchronous flush, and a selectable first-word-fall-through (FWFT) read mode. It also accepts a simultaneous read and write when full. It sits between producer and consumer stages in the same clock domain.

---
 rtl/fifo_pkg.sv | 32 +++
 rtl/fifo_ram.sv | 34 +++
 rtl/fifo_sync_prog.sv | 101 ++++++++++
 tb/tb_fifo_sync_prog.sv | 138 +++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: read-mode constants, status flag bundle and helpers.
// The sync and the future async FIFO both import this package.
package fifo_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  typedef struct packed {
    logic full;
    logic empty;
    logic af;
    logic ae;
  } fifo_flags_t;

  localparam fifo_flags_t FIFO_FLAGS_RST = '{full: 1'b0, empty: 1'b1, af: 1'b0, ae: 1'b1};

  // Occupancy needs one bit more than the pointers to represent 0..DEPTH.
  function automatic int fifo_cnt_w(input int addr_w);
    return addr_w + 1;
  endfunction

  function automatic fifo_flags_t fifo_flags(input int cnt, input int depth,
                                             input int af_th, input int ae_th);
    fifo_flags_t f;
    f.full  = (cnt == depth);
    f.empty = (cnt == 0);
    f.af    = (cnt >= af_th);
    f.ae    = (cnt <= ae_th);
    return f;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port DEPTH x DATA_WIDTH storage, synchronous write.
// Read port is a registered output (REG_RD=1) or combinational (REG_RD=0).
module fifo_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int REG_RD     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  if (REG_RD != 0) begin : g_reg
    // Output register holds its value between reads; only it is reset.
    always_ff @(posedge clk or posedge rst)
      if (rst)     rdata <= '0;
      else if (re) rdata <= mem[raddr];
  end else begin : g_comb
    assign rdata = mem[raddr];
  end

endmodule

// File: rtl/fifo_sync_prog.sv
// Single-clock FIFO with programmable almost-full/empty, occupancy count,
// synchronous flush and standard or first-word-fall-through read mode.
module fifo_sync_prog
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int AF_THRESH  = 28,
  parameter int AE_THRESH  = 4,
  parameter int FWFT       = FIFO_MODE_STD
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = fifo_cnt_w(ADDR_WIDTH);

  if (ADDR_WIDTH < 1) begin : g_chk_aw
    $error("fifo_sync_prog: ADDR_WIDTH must be >= 1");
  end
  if (AE_THRESH >= AF_THRESH) begin : g_chk_th
    $error("fifo_sync_prog: AE_THRESH must be < AF_THRESH");
  end
  if (AF_THRESH > DEPTH) begin : g_chk_af
    $error("fifo_sync_prog: AF_THRESH must be <= DEPTH");
  end

  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]         cnt_nxt;
  logic                  rd_ok, wr_ok;
  fifo_flags_t           flg;

  assign rd_ok = rd_en && !flg.empty;
  // A read in the same cycle frees a slot, so a write into a full FIFO is legal.
  assign wr_ok = wr_en && (!flg.full || rd_en);

  always_comb begin
    cnt_nxt = count;
    if (clear)                cnt_nxt = '0;
    else if (wr_ok && !rd_ok) cnt_nxt = count + CW'(1);
    else if (rd_ok && !wr_ok) cnt_nxt = count - CW'(1);
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      flg       <= FIFO_FLAGS_RST;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      count <= cnt_nxt;
      flg   <= fifo_flags(int'(cnt_nxt), DEPTH, AF_THRESH, AE_THRESH);
      if (clear) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end else begin
        if (wr_ok) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
        if (rd_ok) rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
        overflow  <= wr_en && !wr_ok;
        underflow <= rd_en && !rd_ok;
      end
    end

  assign full         = flg.full;
  assign empty        = flg.empty;
  assign almost_full  = flg.af;
  assign almost_empty = flg.ae;

  fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .REG_RD     ((FWFT == FIFO_MODE_FWFT) ? 0 : 1)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_ok && !clear),
    .waddr (wr_ptr),
    .wdata (data_in),
    .re    (rd_ok && !clear),
    .raddr (rd_ptr),
    .rdata (data_out)
  );

endmodule

// File: tb/tb_fifo_sync_prog.sv
// Drives a standard and an FWFT instance with identical stimulus and checks
// both against a queue-based reference model.
module tb_fifo_sync_prog;
  localparam int DW = 8, AW = 5, DEPTH = 32, AF = 28, AE = 4;

  logic clk = 1'b0, rst = 1'b1, clear = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] dout0, dout1;
  logic full0, empty0, af0, ae0, ovf0, unf0;
  logic full1, empty1, af1, ae1, ovf1, unf1;
  logic [AW:0] cnt0, cnt1;

  always #5 clk = ~clk;

  fifo_sync_prog #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .clear(clear), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .data_out(dout0), .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0),
    .count(cnt0), .overflow(ovf0), .underflow(unf0));

  fifo_sync_prog #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .clear(clear), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .data_out(dout1), .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1),
    .count(cnt1), .overflow(ovf1), .underflow(unf1));

  int n_chk = 0, n_fail = 0;
  logic [DW-1:0] q[$];
  logic [DW-1:0] exp_dout = '0;
  logic exp_ovf = 1'b0, exp_unf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    int n = q.size();
    chk("count",   cnt0, n);              chk("count_fwft", cnt1, n);
    chk("full",    full0, n == DEPTH);    chk("full_fwft",  full1, n == DEPTH);
    chk("empty",   empty0, n == 0);       chk("empty_fwft", empty1, n == 0);
    chk("afull",   af0, n >= AF);         chk("afull_fwft", af1, n >= AF);
    chk("aempty",  ae0, n <= AE);         chk("aempty_fwft", ae1, n <= AE);
    chk("ovf",     ovf0, exp_ovf);        chk("ovf_fwft",   ovf1, exp_ovf);
    chk("unf",     unf0, exp_unf);        chk("unf_fwft",   unf1, exp_unf);
    chk("dout",    dout0, exp_dout);
    if (n > 0) chk("dout_fwft", dout1, q[0]);
  endtask

  // Apply one cycle of stimulus, advance the model, then check after the edge.
  task automatic step(input logic wr, input logic [DW-1:0] din, input logic rd, input logic clr);
    bit rdok, wrok;
    wr_en = wr; data_in = din; rd_en = rd; clear = clr;
    @(posedge clk);
    if (clr) begin
      q.delete();
      exp_ovf = 1'b0; exp_unf = 1'b0;
    end else begin
      rdok = rd && (q.size() > 0);
      wrok = wr && ((q.size() < DEPTH) || rd);
      if (rdok) exp_dout = q.pop_front();
      if (wrok) q.push_back(din);
      exp_ovf = wr && !wrok;
      exp_unf = rd && !rdok;
    end
    #1;
    wr_en = 1'b0; rd_en = 1'b0; clear = 1'b0;
    check_all();
  endtask

  task automatic model_reset();
    q.delete();
    exp_dout = '0; exp_ovf = 1'b0; exp_unf = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] d;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    model_reset();
    check_all();

    // Fill with 0x10..0x2F, then overflow, then write+read while full
    for (int i = 0; i < DEPTH; i++) step(1'b1, DW'(8'h10 + i), 1'b0, 1'b0);
    step(1'b1, 8'hFF, 1'b0, 1'b0);
    step(1'b1, 8'hAA, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, 1'b0);
    // Empty: lone read underflows, then write+read accepts only the write
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, 8'h5A, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // Wrap-around
    d = 8'h40;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 20; i++) begin step(1'b1, d, 1'b0, 1'b0); d++; end
      for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b1, 1'b0);
    end

    // FWFT head visibility and advance
    step(1'b1, 8'h55, 1'b0, 1'b0);
    step(1'b1, 8'h66, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // Clear with a concurrent write at count 10
    for (int i = 0; i < 10; i++) step(1'b1, DW'(8'h80 + i), 1'b0, 1'b0);
    step(1'b1, 8'hEE, 1'b1, 1'b1);
    step(1'b0, '0, 1'b1, 1'b1);

    // Randomised phases biased alternately towards filling and draining
    for (int p = 0; p < 8; p++) begin
      for (int i = 0; i < 250; i++) begin
        bit w, r, c;
        w = (p % 2 == 0) ? ($urandom_range(99) < 80) : ($urandom_range(99) < 30);
        r = (p % 2 == 0) ? ($urandom_range(99) < 30) : ($urandom_range(99) < 80);
        c = ($urandom_range(199) == 0);
        step(w, DW'($urandom), r, c);
      end
    end

    // Asynchronous reset between edges, with data in flight
    for (int i = 0; i < 12; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk); rst = 1'b0;
    step(1'b1, 8'h33, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
